sparc_ifu_thrsched: RTL and testbench

//  Per-thread ready/wait tracker and next-thread picker for the IFU switch stage.

---
 rtl/sparc_ifu_thrsched.sv | 122 ++++++++++++
 tb/tb_sparc_ifu_thrsched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sparc_ifu_thrsched.sv
// IFU switch-stage thread scheduler: per-thread IDLE/RDY/WAIT tracking,
// LRU next-thread pick registered onto thr_f, and a sticky WAIT watchdog.
module sparc_ifu_thrsched #(
  parameter int unsigned TO_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       se,
  input  logic [3:0] thr_active,
  input  logic [3:0] rst_thread,
  input  logic [3:0] completion,
  input  logic       sw_cond_s,
  input  logic [3:0] thr_s,
  input  logic       fcl_stall,
  output logic [3:0] thr_f,
  output logic       thr_vld_f,
  output logic [3:0] thr_rdy,
  output logic [3:0] thr_wait,
  output logic [3:0] wait_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RDY  = 2'd1,
    WAIT = 2'd2
  } thr_state_e;

  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] CNT_PRE = CNT_MAX - 1'b1;

  thr_state_e      state_q [4];
  thr_state_e      state_d [4];
  logic [1:0]      order_q [4];
  logic [1:0]      order_d [4];
  logic [TO_W-1:0] cnt_q   [4];
  logic [3:0]      timeout_q;
  logic [3:0]      thr_f_q;
  logic            vld_q;
  logic [3:0]      cand;
  logic [3:0]      win_oh;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      win_pos;

  // Scan enable only reaches the flops in the physical netlist.
  logic unused_se;
  assign unused_se = se;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      if (!thr_active[i])                                   state_d[i] = IDLE;
      else if (rst_thread[i])                               state_d[i] = WAIT;
      else if (state_q[i] == RDY && sw_cond_s && thr_s[i])  state_d[i] = WAIT;
      else if (state_q[i] == WAIT && completion[i])         state_d[i] = RDY;
      else if (state_q[i] == IDLE)                          state_d[i] = WAIT;
      cand[i] = (state_d[i] == RDY);
    end
  end

  // Walk LRU head->tail for the first ready thread; winner rotates to the tail.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    win_pos = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      if (!found && cand[order_q[p]]) begin
        found   = 1'b1;
        win     = order_q[p];
        win_pos = 2'(p);
      end
    end
    win_oh = '0;
    if (found) win_oh[win] = 1'b1;
    order_d = order_q;
    if (!fcl_stall && found) begin
      for (int unsigned p = 0; p < 3; p++) begin
        if (2'(p) >= win_pos) order_d[p] = order_q[p+1];
      end
      order_d[3] = win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        order_q[i] <= 2'(i);
        cnt_q[i]   <= '0;
      end
      timeout_q <= '0;
      thr_f_q   <= '0;
      vld_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        order_q[i] <= order_d[i];
        if (state_q[i] != WAIT)      cnt_q[i] <= '0;
        else if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
        // Sets on the edge where the counter reaches saturation.
        if (!thr_active[i])                                  timeout_q[i] <= 1'b0;
        else if (state_q[i] == WAIT && cnt_q[i] >= CNT_PRE)  timeout_q[i] <= 1'b1;
      end
      if (!fcl_stall) begin
        thr_f_q <= win_oh;
        vld_q   <= found;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      thr_rdy[i]  = (state_q[i] == RDY);
      thr_wait[i] = (state_q[i] == WAIT);
    end
  end

  assign thr_f        = thr_f_q;
  assign thr_vld_f    = vld_q;
  assign wait_timeout = timeout_q;

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// Bench for sparc_ifu_thrsched: directed vector table, watchdog sequence,
// and random stimulus compared against a queue-based scheduling model.
module tb_sparc_ifu_thrsched;

  localparam int unsigned TW   = 3;
  localparam int          WMAX = 7;

  logic       clk = 1'b0;
  logic       reset, se, sw_cond_s, fcl_stall;
  logic [3:0] thr_active, rst_thread, completion, thr_s;
  logic [3:0] thr_f, thr_rdy, thr_wait, wait_timeout;
  logic       thr_vld_f;

  sparc_ifu_thrsched #(.TO_W(TW)) dut (
    .clk(clk), .reset(reset), .se(se), .thr_active(thr_active),
    .rst_thread(rst_thread), .completion(completion), .sw_cond_s(sw_cond_s),
    .thr_s(thr_s), .fcl_stall(fcl_stall), .thr_f(thr_f), .thr_vld_f(thr_vld_f),
    .thr_rdy(thr_rdy), .thr_wait(thr_wait), .wait_timeout(wait_timeout)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: ready/waiting flags, consecutive wait count, LRU as a queue of ids.
  bit         m_rdy [4];
  bit         m_wt  [4];
  bit         m_to  [4];
  int         m_waited [4];
  int         lru [$];
  logic [3:0] m_f;
  bit         m_vld;

  typedef struct {
    bit rst; logic [3:0] act, rth, comp; bit sw; logic [3:0] ts; bit stall;
    logic [3:0] f; bit vld; logic [3:0] rdy, wt, to;
  } vec_t;
  vec_t tbl [$];

  function automatic logic [3:0] pack(bit b [4]);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = b[i];
    return v;
  endfunction

  task automatic check(string name, logic [3:0] got, logic [3:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic model_step();
    bit nr [4];
    bit nw [4];
    int w;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_rdy[i] = 0; m_wt[i] = 0; m_to[i] = 0; m_waited[i] = 0;
      end
      lru = {0, 1, 2, 3};
      m_f = 4'h0; m_vld = 0;
      return;
    end
    for (int i = 0; i < 4; i++) begin
      nr[i] = m_rdy[i]; nw[i] = m_wt[i];
      if (!thr_active[i])                         begin nr[i] = 0; nw[i] = 0; end
      else if (rst_thread[i])                     begin nr[i] = 0; nw[i] = 1; end
      else if (m_rdy[i] && sw_cond_s && thr_s[i]) begin nr[i] = 0; nw[i] = 1; end
      else if (m_wt[i] && completion[i])          begin nr[i] = 1; nw[i] = 0; end
      else if (!m_rdy[i] && !m_wt[i])             begin nr[i] = 0; nw[i] = 1; end
      m_waited[i] = m_wt[i] ? ((m_waited[i] + 1 > WMAX) ? WMAX : m_waited[i] + 1) : 0;
      if (!thr_active[i])         m_to[i] = 0;
      else if (m_waited[i] == WMAX) m_to[i] = 1;
    end
    if (!fcl_stall) begin
      w = -1;
      for (int k = 0; k < lru.size(); k++) begin
        if (nr[lru[k]]) begin
          w = lru[k];
          lru.delete(k);
          lru.push_back(w);
          break;
        end
      end
      m_vld = (w >= 0);
      m_f   = (w >= 0) ? 4'(1 << w) : 4'h0;
    end
    for (int i = 0; i < 4; i++) begin
      m_rdy[i] = nr[i]; m_wt[i] = nw[i];
    end
  endtask

  task automatic step(bit r, logic [3:0] a, logic [3:0] rth, logic [3:0] c,
                      bit sw, logic [3:0] ts, bit st);
    reset = r; thr_active = a; rst_thread = rth; completion = c;
    sw_cond_s = sw; thr_s = ts; fcl_stall = st;
    @(posedge clk);
    #1;
    model_step();
  endtask

  function automatic vec_t mk(bit r, logic [3:0] a, logic [3:0] rth, logic [3:0] c, bit sw,
                              logic [3:0] ts, bit st, logic [3:0] f, bit v,
                              logic [3:0] rdy, logic [3:0] wt, logic [3:0] to);
    vec_t x;
    x.rst = r; x.act = a; x.rth = rth; x.comp = c; x.sw = sw; x.ts = ts; x.stall = st;
    x.f = f; x.vld = v; x.rdy = rdy; x.wt = wt; x.to = to;
    return x;
  endfunction

  initial begin
    reset = 1; se = 0; thr_active = 0; rst_thread = 0; completion = 0;
    sw_cond_s = 0; thr_s = 0; fcl_stall = 0;
    for (int i = 0; i < 4; i++) begin
      m_rdy[i] = 0; m_wt[i] = 0; m_to[i] = 0; m_waited[i] = 0;
    end
    lru = {0, 1, 2, 3}; m_f = 0; m_vld = 0;

    //           rst act  rth  comp sw ts   st   f    v  rdy  wt   to
    tbl.push_back(mk(1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'hF, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'hF, 0, 4'h0, 0, 4'h1, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h2, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h8, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h1, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 1, 4'h2, 0, 4'h4, 1, 4'hD, 4'h2, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h8, 1, 4'hD, 4'h2, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h2, 0, 4'h0, 0, 4'h2, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h1, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 1, 4'h4, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 1, 4'h4, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 1, 4'h4, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h8, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h2, 1, 4'hF, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h8, 1, 4'h8, 0, 4'h1, 1, 4'h7, 4'h8, 4'h0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 1, 4'h6, 4'h8, 4'h0));
    tbl.push_back(mk(0, 4'hE, 4'h0, 4'h1, 0, 4'h0, 0, 4'h2, 1, 4'h6, 4'h8, 4'h0));
    tbl.push_back(mk(1, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0, 4'hF, 4'h0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 4'hF, 0, 4'h0, 0, 4'h1, 1, 4'hF, 4'h0, 4'h0));

    foreach (tbl[n]) begin
      step(tbl[n].rst, tbl[n].act, tbl[n].rth, tbl[n].comp, tbl[n].sw, tbl[n].ts, tbl[n].stall);
      check($sformatf("vec%0d_thr_f", n), thr_f, tbl[n].f);
      check($sformatf("vec%0d_vld", n), {3'b0, thr_vld_f}, {3'b0, tbl[n].vld});
      check($sformatf("vec%0d_rdy", n), thr_rdy, tbl[n].rdy);
      check($sformatf("vec%0d_wait", n), thr_wait, tbl[n].wt);
      check($sformatf("vec%0d_timeout", n), wait_timeout, tbl[n].to);
    end

    // Watchdog: T0 alone in WAIT saturates after 7 waiting cycles.
    step(1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
    step(0, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    check("wd_enter_wait", thr_wait, 4'h1);
    for (int k = 1; k <= 6; k++) begin
      step(0, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
      check($sformatf("wd_pre%0d", k), wait_timeout, 4'h0);
    end
    step(0, 4'h1, 4'h0, 4'h0, 0, 4'h0, 0);
    check("wd_fire", wait_timeout, 4'h1);
    step(0, 4'h1, 4'h0, 4'h1, 0, 4'h0, 0);
    check("wd_sticky", wait_timeout, 4'h1);
    check("wd_resume_rdy", thr_rdy, 4'h1);
    check("wd_resume_pick", thr_f, 4'h1);
    step(0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
    check("wd_clear", wait_timeout, 4'h0);
    check("wd_idle", thr_rdy | thr_wait, 4'h0);

    // Random traffic against the model.
    step(1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0);
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] a, rth, c, ts;
      bit r, sw, st;
      r   = ($urandom_range(63) == 0);
      a   = ($urandom_range(7) == 0) ? 4'($urandom) : 4'hF;
      rth = ($urandom_range(15) == 0) ? 4'($urandom) : 4'h0;
      c   = 4'($urandom) & 4'($urandom);
      sw  = ($urandom_range(3) == 0);
      ts  = 4'(1 << $urandom_range(3));
      st  = ($urandom_range(4) == 0);
      step(r, a, rth, c, sw, ts, st);
      check("rnd_thr_f", thr_f, m_f);
      check("rnd_vld", {3'b0, thr_vld_f}, {3'b0, m_vld});
      check("rnd_rdy", thr_rdy, pack(m_rdy));
      check("rnd_wait", thr_wait, pack(m_wt));
      check("rnd_timeout", wait_timeout, pack(m_to));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
